// File: rtl/ssd_scan_mux_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_mux_if
//   Bundles the value/control inputs and the display-side outputs of the
//   seven-segment scan controller.
//   master : the side that supplies value_in/load/lz_en and observes outputs
//   slave  : the scan controller itself
//   value_in    [4*NUM_DIGITS-1:0] nibble i = value_in[4i+3:4i], digit 0 = LSD
//   load        capture value_in into the pending buffer
//   lz_en       blank leading zero digits (digit 0 never blanked)
//   dig         [3:0] nibble of the digit being scanned
//   digit_an_n  [NUM_DIGITS-1:0] active-low digit enables
//   digit_idx   [2:0] index of the digit being scanned
//   pending_vld a loaded value waits for the next frame boundary
//   frame_done  one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
interface ssd_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    lz_en;
    logic [3:0]              dig;
    logic [NUM_DIGITS-1:0]   digit_an_n;
    logic [2:0]              digit_idx;
    logic                    pending_vld;
    logic                    frame_done;

    modport master (
        output value_in, load, lz_en,
        input  dig, digit_an_n, digit_idx, pending_vld, frame_done
    );

    modport slave (
        input  value_in, load, lz_en,
        output dig, digit_an_n, digit_idx, pending_vld, frame_done
    );
endinterface

// File: rtl/ssd_scan_mux.sv
// ---------------------------------------------------------------------------
// ssd_scan_mux
//   Time-multiplexed scan controller for a common-anode seven-segment display.
//   Scans NUM_DIGITS digits, SLOT_CYCLES clocks each; the first BLANK_CYCLES
//   of every slot keep all digits off to avoid ghosting. The displayed value
//   is double-buffered and only changes at a frame boundary. Optional
//   leading-zero suppression.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     sif    ssd_scan_mux_if.slave (value/control in, display outputs)
//
//   Slot phase (decoded from slot_cnt):
//     state    | meaning
//     PH_BLANK | slot_cnt <  BLANK_CYCLES, all digit enables high
//     PH_DRIVE | slot_cnt >= BLANK_CYCLES, current digit enabled unless suppressed
// ---------------------------------------------------------------------------
module ssd_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    ssd_scan_mux_if.slave sif
);
    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    logic [CW-1:0]         r_slot_cnt;
    logic [2:0]            r_digit_idx;
    logic [VW-1:0]         r_active;
    logic [VW-1:0]         r_pending;
    logic                  r_pending_vld;
    logic [3:0]            r_dig;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                  r_frame_done;

    logic                  w_slot_wrap;
    logic                  w_boundary;
    logic [CW-1:0]         w_slot_nxt;
    logic [2:0]            w_idx_nxt;
    logic [VW-1:0]         w_active_nxt;
    logic [VW-1:0]         w_pending_nxt;
    logic                  w_pvld_nxt;
    phase_t                w_phase_nxt;
    logic [3:0]            w_dig_nxt;
    logic [NUM_DIGITS-1:0] w_an_n_nxt;
    logic                  w_fd_nxt;
    logic                  w_zero_run;

    assign w_slot_wrap = (r_slot_cnt == CW'(SLOT_CYCLES - 1));
    assign w_boundary  = w_slot_wrap && (r_digit_idx == 3'(NUM_DIGITS - 1));

    // Outputs are registered from the next-state values so they change on
    // the same edge as slot_cnt/digit_idx and never see an input directly.
    always_comb begin
        w_slot_nxt    = w_slot_wrap ? '0 : r_slot_cnt + CW'(1);
        w_idx_nxt     = r_digit_idx;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_pvld_nxt    = r_pending_vld;
        w_dig_nxt     = 4'h0;
        w_an_n_nxt    = '1;
        w_zero_run    = 1'b1;

        if (w_slot_wrap) begin
            w_idx_nxt = (r_digit_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_digit_idx + 3'd1;
        end

        // A load coinciding with the boundary bypasses the pending buffer.
        if (w_boundary) begin
            if (sif.load) begin
                w_active_nxt = sif.value_in;
            end else if (r_pending_vld) begin
                w_active_nxt = r_pending;
            end
            w_pvld_nxt = 1'b0;
        end else if (sif.load) begin
            w_pending_nxt = sif.value_in;
            w_pvld_nxt    = 1'b1;
        end

        w_phase_nxt = (w_slot_nxt < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;

        // Walk from the most significant digit down; w_zero_run stays set
        // while every nibble from the top down to digit i is zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_active_nxt[4*i +: 4] == 4'h0);
            if (w_idx_nxt == 3'(i)) begin
                w_dig_nxt = w_active_nxt[4*i +: 4];
                if ((w_phase_nxt == PH_DRIVE) && !((i > 0) && sif.lz_en && w_zero_run)) begin
                    w_an_n_nxt[i] = 1'b0;
                end
            end
        end

        w_fd_nxt = (w_slot_nxt == CW'(SLOT_CYCLES - 1)) && (w_idx_nxt == 3'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= 3'd0;
            r_active      <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_dig         <= 4'h0;
            r_an_n        <= '1;
            r_frame_done  <= 1'b0;
        end else begin
            r_slot_cnt    <= w_slot_nxt;
            r_digit_idx   <= w_idx_nxt;
            r_active      <= w_active_nxt;
            r_pending     <= w_pending_nxt;
            r_pending_vld <= w_pvld_nxt;
            r_dig         <= w_dig_nxt;
            r_an_n        <= w_an_n_nxt;
            r_frame_done  <= w_fd_nxt;
        end
    end

    assign sif.dig         = r_dig;
    assign sif.digit_an_n  = r_an_n;
    assign sif.digit_idx   = r_digit_idx;
    assign sif.pending_vld = r_pending_vld;
    assign sif.frame_done  = r_frame_done;
endmodule

// File: tb/tb_ssd_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_mux
//   Self-checking bench for ssd_scan_mux (NUM_DIGITS=4, SLOT_CYCLES=8,
//   BLANK_CYCLES=2). A reference model derives every expected output from the
//   cycle count since reset release plus the displayed/pending values.
// ---------------------------------------------------------------------------
module tb_ssd_scan_mux;
    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = N * S;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd_scan_mux_if #(.NUM_DIGITS(N)) sif ();

    ssd_scan_mux #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sif  (sif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_pvld;
    bit          m_lz_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=0x%0h exp=0x%0h", tag, m_t, got, exp);
    endtask

    function automatic bit frame_last();
        return ((m_t % S) == S - 1) && (((m_t / S) % N) == N - 1);
    endfunction

    task automatic check_cycle();
        int          slot;
        int          idx;
        logic [3:0]  exp_an;
        logic [15:0] upper;
        slot   = m_t % S;
        idx    = (m_t / S) % N;
        upper  = m_active >> (4 * idx);
        exp_an = 4'hF;
        if (slot >= B && !(idx > 0 && m_lz_prev && upper == 16'h0)) exp_an[idx] = 1'b0;
        check("dig",   32'(sif.dig),         32'(upper & 16'hF));
        check("an",    32'(sif.digit_an_n),  32'(exp_an));
        check("idx",   32'(sif.digit_idx),   32'(idx));
        check("pvld",  32'(sif.pending_vld), 32'(m_pvld));
        check("fdone", 32'(sif.frame_done),  32'(frame_last()));
    endtask

    // One clock cycle: check outputs, drive inputs, advance model, move to
    // 1 time unit past the next rising edge.
    task automatic step(input bit ld, input logic [15:0] v, input bit lz);
        check_cycle();
        sif.load     = ld;
        sif.value_in = v;
        sif.lz_en    = lz;
        if (frame_last()) begin
            if (ld) m_active = v;
            else if (m_pvld) m_active = m_pending;
            m_pvld = 1'b0;
        end else if (ld) begin
            m_pending = v;
            m_pvld    = 1'b1;
        end
        m_lz_prev = lz;
        m_t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit lz);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), lz);
    endtask

    task automatic idle_until_phase(input int ph, input bit lz);
        while ((m_t % F) != ph) step(1'b0, 16'($urandom), lz);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        m_t       = 0;
        m_active  = '0;
        m_pending = '0;
        m_pvld    = 1'b0;
        m_lz_prev = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        int          k;
        bit          lz;

        sif.load     = 1'b0;
        sif.value_in = '0;
        sif.lz_en    = 1'b0;
        m_t          = 0;
        m_active     = '0;
        m_pending    = '0;
        m_pvld       = 1'b0;
        m_lz_prev    = 1'b0;

        // reset held 3 cycles, load attempts ignored
        sif.load     = 1'b1;
        sif.value_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_an",   32'(sif.digit_an_n),  32'hF);
            check("rst_dig",  32'(sif.dig),         32'h0);
            check("rst_pvld", 32'(sif.pending_vld), 32'h0);
            check("rst_fd",   32'(sif.frame_done),  32'h0);
        end
        sif.load = 1'b0;
        release_reset();

        // first frame idle, then scan order with 1234
        idle(F, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        idle_until_phase(0, 1'b0);
        idle(2 * F, 1'b0);

        // double buffering: ABCD mid-frame, then 0001 overwrites it
        idle_until_phase(13, 1'b0);
        step(1'b1, 16'hABCD, 1'b0);
        idle_until_phase(0, 1'b0);
        idle(F, 1'b0);
        idle_until_phase(9, 1'b0);
        step(1'b1, 16'hABCD, 1'b0);
        idle_until_phase(25, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        idle_until_phase(0, 1'b0);
        idle(F, 1'b0);

        // leading zeros
        step(1'b1, 16'h0070, 1'b1);
        idle_until_phase(0, 1'b1);
        idle(2 * F, 1'b1);
        idle(F, 1'b0);
        step(1'b1, 16'h0000, 1'b1);
        idle_until_phase(0, 1'b1);
        idle(2 * F, 1'b1);

        // load exactly in the frame_done cycle
        idle_until_phase(F - 1, 1'b0);
        step(1'b1, 16'h5A5A, 1'b0);
        idle(F, 1'b0);

        // randomized traffic
        lz = 1'b0;
        for (int i = 0; i < 60 * F; i++) begin
            v = 16'($urandom);
            k = $urandom_range(0, 4);
            v = v & (16'hFFFF >> (4 * k));
            if ($urandom_range(0, 63) == 0) lz = ~lz;
            step(($urandom_range(0, 11) == 0), v, lz);
        end

        // mid-frame reset during DRIVE of digit 2, with a value pending
        idle_until_phase(2 * S + B + 1, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0);
        check("pre_rst_an", 32'(sif.digit_an_n), 32'hB);
        rst_n = 1'b0;
        #1;
        check("async_an",   32'(sif.digit_an_n),  32'hF);
        check("async_dig",  32'(sif.dig),         32'h0);
        check("async_idx",  32'(sif.digit_idx),   32'h0);
        check("async_pvld", 32'(sif.pending_vld), 32'h0);
        @(posedge clk);
        @(posedge clk);
        release_reset();
        idle(2 * F, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
